// File: rtl/fb_pixel_writer_if.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer_if
// Purpose : bundles the pixel stream handshake (from the line drawer) and the
//           single-port framebuffer write port used by fb_pixel_writer.
// Signals :
//   pix_valid            pixel present (driven by the drawer's "drawing")
//   pix_x / pix_y        signed pixel coordinates
//   pix_color            pixel colour
//   pix_ready            writer can accept a pixel (drives the drawer's "oe")
//   mem_grant            memory accepts the presented write this cycle
//   mem_addr/data/we     framebuffer write port
// Modports:
//   master : pixel source + memory model side
//   slave  : fb_pixel_writer side
// ---------------------------------------------------------------------------
interface fb_pixel_writer_if #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 17
);

  logic                          pix_valid;
  logic signed [COORD_WIDTH-1:0] pix_x;
  logic signed [COORD_WIDTH-1:0] pix_y;
  logic [COLOR_WIDTH-1:0]        pix_color;
  logic                          pix_ready;

  logic                          mem_grant;
  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic [COLOR_WIDTH-1:0]        mem_data;
  logic                          mem_we;

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, mem_grant,
    input  pix_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, mem_grant,
    output pix_ready, mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// fb_pixel_writer
// Purpose : takes the line drawer's pixel stream, clips off-screen pixels,
//           converts (x,y) to a linear address in a two-stage pipeline and
//           writes the pixel into a single-port framebuffer. An optional
//           clear engine fills the whole framebuffer with one colour.
// Ports   :
//   clk_in        single clock
//   rst_in        synchronous active-high reset
//   bus           fb_pixel_writer_if.slave (pixel stream + memory write port)
//   clear_start   one-cycle clear request (honoured only when idle)
//   clear_color   fill colour, sampled when clear_start is accepted
//   clipped_count saturating count of pixels dropped by clipping
//   busy          pipeline holds a pixel or the clear FSM is not idle
//   clear_done    one-cycle pulse after the last clear write
// Config  : define FB_PIXEL_WRITER_CLEAR_EN to build the clear engine
//           (DRAIN/CLEAR states). Without it the block is permanently idle,
//           clear_start/clear_color are ignored and clear_done is tied 0.
// ---------------------------------------------------------------------------
module fb_pixel_writer #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned FB_WIDTH    = 320,
  parameter int unsigned FB_HEIGHT   = 240,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH  = 17
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  fb_pixel_writer_if.slave       bus,
  input  logic                   clear_start,
  input  logic [COLOR_WIDTH-1:0] clear_color,
  output logic [15:0]            clipped_count,
  output logic                   busy,
  output logic                   clear_done
);

  localparam logic [ADDR_WIDTH-1:0]         FBW_A = ADDR_WIDTH'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] FBW_C = COORD_WIDTH'(FB_WIDTH);
  localparam logic signed [COORD_WIDTH-1:0] FBH_C = COORD_WIDTH'(FB_HEIGHT);
  localparam logic [15:0]                   CLIP_MAX = 16'hFFFF;

  // Stage 1: raw coordinates, colour and in-bounds flag
  logic                          r_s1_valid;
  logic signed [COORD_WIDTH-1:0] r_s1_x;
  logic signed [COORD_WIDTH-1:0] r_s1_y;
  logic [COLOR_WIDTH-1:0]        r_s1_color;
  logic                          r_s1_inb;

  // Stage 2: linear address and colour, presented to memory
  logic                          r_s2_valid;
  logic [ADDR_WIDTH-1:0]         r_s2_addr;
  logic [COLOR_WIDTH-1:0]        r_s2_color;
  logic                          r_s2_inb;

  logic [15:0]                   r_clip_cnt;

  logic                          w_idle;
  logic                          w_clip_zero;
  logic                          w_in_bounds;
  logic                          w_s2_retire;
  logic                          w_s2_adv;
  logic                          w_pix_ready;
  logic                          w_handshake;
  logic [ADDR_WIDTH-1:0]         w_lin_addr;

  // Negative coordinates have the sign bit set; the upper limits are signed compares
  assign w_in_bounds = !bus.pix_x[COORD_WIDTH-1] && (bus.pix_x < FBW_C) &&
                       !bus.pix_y[COORD_WIDTH-1] && (bus.pix_y < FBH_C);

  // Address is only meaningful for in-bounds entries, so the unsigned view is safe
  assign w_lin_addr = ADDR_WIDTH'($unsigned(r_s1_y)) * FBW_A +
                      ADDR_WIDTH'($unsigned(r_s1_x));

  // An in-bounds entry retires on grant; an out-of-bounds one retires at once
  assign w_s2_retire = r_s2_valid && (!r_s2_inb || bus.mem_grant);
  assign w_s2_adv    = !r_s2_valid || w_s2_retire;

  // Built only from state and mem_grant, never from pix_valid
  assign w_pix_ready = w_idle && (!r_s1_valid || w_s2_adv) && !rst_in;
  assign w_handshake = bus.pix_valid && w_pix_ready;

  assign bus.pix_ready = w_pix_ready;

  // Two-stage pixel pipeline
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_color <= '0;
      r_s1_inb   <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_addr  <= '0;
      r_s2_color <= '0;
      r_s2_inb   <= 1'b0;
    end else begin
      if (w_handshake) begin
        r_s1_valid <= 1'b1;
        r_s1_x     <= bus.pix_x;
        r_s1_y     <= bus.pix_y;
        r_s1_color <= bus.pix_color;
        r_s1_inb   <= w_in_bounds;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end

      // S2 payload only reloads from a real S1 entry, keeping the port quiet otherwise
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_addr  <= w_lin_addr;
          r_s2_color <= r_s1_color;
          r_s2_inb   <= r_s1_inb;
        end
      end
    end
  end

  // Saturating count of clipped pixels, zeroed when a clear is accepted
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_clip_cnt <= '0;
    end else if (w_clip_zero) begin
      r_clip_cnt <= '0;
    end else if (r_s2_valid && !r_s2_inb && (r_clip_cnt != CLIP_MAX)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  assign clipped_count = r_clip_cnt;
  assign busy          = r_s1_valid || r_s2_valid || !w_idle;

`ifdef FB_PIXEL_WRITER_CLEAR_EN

  localparam int unsigned           FB_PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_clr_addr;
  logic [COLOR_WIDTH-1:0] r_clr_color;
  logic                   r_clr_done;
  logic                   w_clearing;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_clearing  = (r_state == ST_CLEAR);
  assign w_clip_zero = w_idle && clear_start;

  // Clear engine: wait for the pipeline to empty, then sweep every address
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= ST_IDLE;
      r_clr_addr  <= '0;
      r_clr_color <= '0;
      r_clr_done  <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear_start) begin
            r_clr_color <= clear_color;
            r_state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A pixel accepted alongside clear_start is still in flight here
          if (!r_s1_valid && !r_s2_valid) begin
            r_clr_addr <= '0;
            r_state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (bus.mem_grant) begin
            if (r_clr_addr == LAST_ADDR) begin
              r_clr_addr <= '0;
              r_clr_done <= 1'b1;
              r_state    <= ST_IDLE;
            end else begin
              r_clr_addr <= r_clr_addr + ADDR_WIDTH'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The pipeline is empty during CLEAR, so the sweep owns the write port
  assign bus.mem_we   = w_clearing || (r_s2_valid && r_s2_inb);
  assign bus.mem_addr = w_clearing ? r_clr_addr  : r_s2_addr;
  assign bus.mem_data = w_clearing ? r_clr_color : r_s2_color;
  assign clear_done   = r_clr_done;

`else

  logic w_unused_clear;

  assign w_idle         = 1'b1;
  assign w_clip_zero    = 1'b0;
  assign w_unused_clear = ^{clear_start, clear_color};

  assign bus.mem_we   = r_s2_valid && r_s2_inb;
  assign bus.mem_addr = r_s2_addr;
  assign bus.mem_data = r_s2_color;
  assign clear_done   = 1'b0;

`endif

endmodule

// File: tb/tb_fb_pixel_writer.sv
// ---------------------------------------------------------------------------
// tb_fb_pixel_writer
// Self-checking bench for fb_pixel_writer (320x240, 8-bit colour).
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fb_pixel_writer;

  localparam int unsigned COORD_WIDTH = 16;
  localparam int unsigned FB_WIDTH    = 320;
  localparam int unsigned FB_HEIGHT   = 240;
  localparam int unsigned COLOR_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH  = 17;

  typedef struct {
    logic                          v;
    logic signed [COORD_WIDTH-1:0] x;
    logic signed [COORD_WIDTH-1:0] y;
    logic [COLOR_WIDTH-1:0]        col;
    logic                          g;
    logic                          e_rdy;
    logic                          e_we;
    logic [ADDR_WIDTH-1:0]         e_addr;
    logic [COLOR_WIDTH-1:0]        e_data;
    logic                          e_busy;
  } vec_t;

  logic                   clk;
  logic                   rst;
  logic                   clear_start;
  logic [COLOR_WIDTH-1:0] clear_color;
  logic [15:0]            clipped_count;
  logic                   busy;
  logic                   clear_done;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  fb_pixel_writer_if #(
    .COORD_WIDTH (COORD_WIDTH),
    .COLOR_WIDTH (COLOR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) bus ();

  fb_pixel_writer #(
    .COORD_WIDTH (COORD_WIDTH),
    .FB_WIDTH    (FB_WIDTH),
    .FB_HEIGHT   (FB_HEIGHT),
    .COLOR_WIDTH (COLOR_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .bus           (bus),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clipped_count (clipped_count),
    .busy          (busy),
    .clear_done    (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic v, input int x, input int y, input int col,
                              input logic g, input logic rdy, input logic we,
                              input int addr, input int data, input logic bsy);
    vec_t r;
    r.v = v;  r.x = 16'(x);  r.y = 16'(y);  r.col = 8'(col);  r.g = g;
    r.e_rdy = rdy;  r.e_we = we;  r.e_addr = 17'(addr);  r.e_data = 8'(data);
    r.e_busy = bsy;
    vecs.push_back(r);
  endfunction

  task automatic drive_pix(input logic v, input int x, input int y, input int col);
    bus.pix_valid = v;
    bus.pix_x     = 16'(x);
    bus.pix_y     = 16'(y);
    bus.pix_color = 8'(col);
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    @(negedge clk);
    bus.pix_valid = r.v;
    bus.pix_x     = r.x;
    bus.pix_y     = r.y;
    bus.pix_color = r.col;
    bus.mem_grant = r.g;
    #1;
    check($sformatf("row%0d_ready", idx), 32'(bus.pix_ready), 32'(r.e_rdy));
    check($sformatf("row%0d_we", idx), 32'(bus.mem_we), 32'(r.e_we));
    if (r.e_we) begin
      check($sformatf("row%0d_addr", idx), 32'(bus.mem_addr), 32'(r.e_addr));
      check($sformatf("row%0d_data", idx), 32'(bus.mem_data), 32'(r.e_data));
    end
    check($sformatf("row%0d_busy", idx), 32'(busy), 32'(r.e_busy));
  endtask

  initial begin
    int cnt;

    // ---- vector table ----
    // single pixel (5,3): address 3*320+5 = 965
    add(1, 5, 3, 'hAA, 1,  1, 0, 0, 0, 0);
    add(0, 0, 0, 0,    1,  1, 0, 0, 0, 1);
    add(0, 0, 0, 0,    1,  1, 1, 965, 'hAA, 1);
    add(0, 0, 0, 0,    1,  1, 0, 0, 0, 0);
    // 10 streamed pixels on row 10: address 3200+k, colour 0x10+k
    for (int k = 0; k < 13; k++)
      add(k < 10, k, 10, 'h10 + k, 1, 1, (k >= 2 && k < 12), 3200 + k - 2, 'h10 + k - 2,
          (k >= 1 && k < 12));
    // clipping: three off-screen pixels then the last on-screen corner
    add(1, -1, 0,     1,     1,  1, 0, 0, 0, 0);
    add(1, 320, 5,    2,     1,  1, 0, 0, 0, 1);
    add(1, 0, 240,    3,     1,  1, 0, 0, 0, 1);
    add(1, 319, 239, 'h5A,   1,  1, 0, 0, 0, 1);
    add(0, 0, 0,      0,     1,  1, 0, 0, 0, 1);
    add(0, 0, 0,      0,     1,  1, 1, 76799, 'h5A, 1);
    add(0, 0, 0,      0,     1,  1, 0, 0, 0, 0);
    // backpressure: P(i)=(100+i,50) -> address 16100+i, colour 0x30+i
    add(1, 100, 50, 'h30, 1,  1, 0, 0, 0, 0);
    add(1, 101, 50, 'h31, 1,  1, 0, 0, 0, 1);
    add(1, 102, 50, 'h32, 1,  1, 1, 16100, 'h30, 1);
    for (int k = 0; k < 5; k++)
      add(1, 103, 50, 'h33, 0,  0, 1, 16101, 'h31, 1);
    add(1, 103, 50, 'h33, 1,  1, 1, 16101, 'h31, 1);
    add(1, 104, 50, 'h34, 1,  1, 1, 16102, 'h32, 1);
    add(0, 0, 0, 0,       1,  1, 1, 16103, 'h33, 1);
    add(0, 0, 0, 0,       1,  1, 1, 16104, 'h34, 1);
    add(0, 0, 0, 0,       1,  1, 0, 0, 0, 0);

    // ---- reset values ----
    rst = 1'b1;
    clear_start = 1'b0;
    clear_color = '0;
    bus.mem_grant = 1'b1;
    drive_pix(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_pix_ready", 32'(bus.pix_ready), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_data", 32'(bus.mem_data), 0);
    check("rst_clear_done", 32'(clear_done), 0);
    check("rst_clipped", 32'(clipped_count), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.pix_ready), 1);

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) apply_row(vecs[i], i);
    #1;
    check("clipped_after_table", 32'(clipped_count), 3);

    // ---- reset mid-pipeline discards the pixel and the clip count ----
    @(negedge clk); drive_pix(1, 7, 7, 'h44); bus.mem_grant = 1'b1;
    @(negedge clk); drive_pix(0, 0, 0, 0);
    #1; rst = 1'b1;
    @(negedge clk); #1;
    check("midpipe_rst_busy", 32'(busy), 0);
    check("midpipe_rst_we", 32'(bus.mem_we), 0);
    check("midpipe_rst_clipped", 32'(clipped_count), 0);
    check("midpipe_rst_ready", 32'(bus.pix_ready), 0);
    rst = 1'b0;
    #1;
    check("midpipe_post_ready", 32'(bus.pix_ready), 1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      if (bus.mem_we) cnt++;
    end
    check("midpipe_no_write", 32'(cnt), 0);

`ifdef FB_PIXEL_WRITER_CLEAR_EN
    begin
      int  exp_idx, n_seq_bad, n_rdy_bad, n_hold_bad, n_late;
      logic done_seen, hold_pend, found;
      logic [ADDR_WIDTH-1:0]  hold_addr, e_addr;
      logic [COLOR_WIDTH-1:0] hold_data, e_data;

      // make the clip count non-zero so the clear visibly zeroes it
      @(negedge clk); drive_pix(1, -3, 2, 0);
      @(negedge clk); drive_pix(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      check("clr_pre_clipped", 32'(clipped_count), 1);

      @(negedge clk); drive_pix(1, 1, 1, 'h77); #1;
      check("clr_pix0_ready", 32'(bus.pix_ready), 1);
      @(negedge clk); drive_pix(1, 2, 1, 'h78); clear_start = 1'b1; clear_color = 'h11; #1;
      check("clr_pix1_ready", 32'(bus.pix_ready), 1);
      @(negedge clk); drive_pix(1, 9, 9, 'h99); clear_start = 1'b0; clear_color = 'hEE; #1;
      check("clr_drain_ready", 32'(bus.pix_ready), 0);
      check("clr_pix0_we", 32'(bus.mem_we), 1);
      check("clr_pix0_addr", 32'(bus.mem_addr), 321);
      check("clr_pix0_data", 32'(bus.mem_data), 'h77);
      check("clr_drain_busy", 32'(busy), 1);

      // expected write stream: (322,0x78) then 0..76799 of 0x11
      exp_idx = 0; n_seq_bad = 0; n_rdy_bad = 0; n_hold_bad = 0;
      done_seen = 1'b0; hold_pend = 1'b0; hold_addr = '0; hold_data = '0;
      for (int cyc = 0; cyc < 80000; cyc++) begin
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.mem_grant = !(cyc == 3 || cyc == 4 || cyc == 40000 || cyc == 40001 || cyc == 40002);
        #1;
        if (clear_done) begin
          done_seen = 1'b1;
          break;
        end
        if (bus.pix_ready) n_rdy_bad++;
        if (hold_pend && (!bus.mem_we || bus.mem_addr !== hold_addr || bus.mem_data !== hold_data))
          n_hold_bad++;
        hold_pend = bus.mem_we && !bus.mem_grant;
        hold_addr = bus.mem_addr;
        hold_data = bus.mem_data;
        if (bus.mem_we && bus.mem_grant) begin
          if (exp_idx == 0) begin
            e_addr = 17'd322; e_data = 8'h78;
          end else begin
            e_addr = 17'(exp_idx - 1); e_data = 8'h11;
          end
          if (bus.mem_addr !== e_addr || bus.mem_data !== e_data) n_seq_bad++;
          exp_idx++;
        end
      end
      check("clr_done_seen", 32'(done_seen), 1);
      check("clr_write_count", 32'(exp_idx), 76801);
      check("clr_write_seq_bad", 32'(n_seq_bad), 0);
      check("clr_ready_low_bad", 32'(n_rdy_bad), 0);
      check("clr_stall_hold_bad", 32'(n_hold_bad), 0);
      check("clr_done_cycle_we", 32'(bus.mem_we), 0);
      check("clr_done_cycle_ready", 32'(bus.pix_ready), 1);
      check("clr_done_cycle_busy", 32'(busy), 0);
      @(negedge clk); #1;
      check("clr_done_pulse_width", 32'(clear_done), 0);
      check("clr_clipped_zeroed", 32'(clipped_count), 0);

      // reset in the middle of a second clear
      @(negedge clk); bus.mem_grant = 1'b1; clear_start = 1'b1; clear_color = 'h22;
      found = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
        @(negedge clk); clear_start = 1'b0; #1;
        if (bus.mem_we && bus.mem_addr == 17'd100) begin
          found = 1'b1;
          break;
        end
      end
      check("rstclr_reached_100", 32'(found), 1);
      check("rstclr_data_at_100", 32'(bus.mem_data), 'h22);
      rst = 1'b1;
      @(negedge clk); #1;
      check("rstclr_we", 32'(bus.mem_we), 0);
      check("rstclr_addr", 32'(bus.mem_addr), 0);
      check("rstclr_data", 32'(bus.mem_data), 0);
      check("rstclr_done", 32'(clear_done), 0);
      check("rstclr_busy", 32'(busy), 0);
      check("rstclr_ready_in_rst", 32'(bus.pix_ready), 0);
      rst = 1'b0;
      #1;
      check("rstclr_ready_after", 32'(bus.pix_ready), 1);
      n_late = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk); #1;
        if (clear_done || bus.mem_we) n_late++;
      end
      check("rstclr_no_activity", 32'(n_late), 0);
    end
`else
    begin
      int n_late;
      // clear request is ignored in this build
      @(negedge clk); drive_pix(1, -5, -5, 0); bus.mem_grant = 1'b1;
      @(negedge clk); drive_pix(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      check("noclr_pre_clipped", 32'(clipped_count), 1);
      @(negedge clk); drive_pix(1, 1, 1, 'h66); clear_start = 1'b1; clear_color = 'h33; #1;
      check("noclr_start_ready", 32'(bus.pix_ready), 1);
      @(negedge clk); drive_pix(0, 0, 0, 0); clear_start = 1'b0; #1;
      check("noclr_next_ready", 32'(bus.pix_ready), 1);
      check("noclr_clipped_kept", 32'(clipped_count), 1);
      @(negedge clk); #1;
      check("noclr_pix_we", 32'(bus.mem_we), 1);
      check("noclr_pix_addr", 32'(bus.mem_addr), 321);
      check("noclr_pix_data", 32'(bus.mem_data), 'h66);
      @(negedge clk); #1;
      check("noclr_idle_busy", 32'(busy), 0);
      n_late = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        if (clear_done || bus.mem_we) n_late++;
      end
      check("noclr_no_activity", 32'(n_late), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
